// File: rtl/fft_sequencer_if.sv
// Operation request/completion bus between the FFT sequencer and the
// butterfly/swap execution unit.
interface fft_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                    o_op_valid;
  logic                    i_op_ready;
  logic                    i_op_done;
  logic                    o_op_swap;
  logic [ADDR_WIDTH-1:0]   o_addr_a;
  logic [ADDR_WIDTH-1:0]   o_addr_b;
  logic [ADDR_WIDTH-2:0]   o_twiddle;
  logic [3:0]              o_stage;

  // Sequencer side
  modport master (
    output o_op_valid, o_op_swap, o_addr_a, o_addr_b, o_twiddle, o_stage,
    input  i_op_ready, i_op_done
  );

  // Execution unit side
  modport slave (
    input  o_op_valid, o_op_swap, o_addr_a, o_addr_b, o_twiddle, o_stage,
    output i_op_ready, i_op_done
  );
endinterface

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIT FFT sequencer: a bit-reversal swap pass followed by
// every butterfly of every stage, one operation in flight at a time.
module fft_sequencer #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [3:0]       i_log2n,
  output logic             o_busy,
  output logic             o_calc_end,
  fft_sequencer_if.master  op
);
  localparam int unsigned TW_WIDTH = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BITREV    = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_log2n, w_log2n_nxt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
  logic [ADDR_WIDTH-1:0] r_k, w_k_nxt;
  logic [3:0]            r_s, w_s_nxt;

  logic [ADDR_WIDTH-1:0] w_n_m1, w_k_last, w_rev_full, w_rev;
  logic                  w_legal, w_swap_hit;

  logic [ADDR_WIDTH-1:0] w_half, w_pos, w_grp, w_bf_a, w_bf_b;
  logic [TW_WIDTH-1:0]   w_bf_tw;

  logic                  w_busy_nxt, w_calc_end_nxt, w_valid_nxt, w_load, w_clear, w_swap_nxt;

  logic                  r_busy, r_calc_end, r_op_valid, r_op_swap;
  logic [ADDR_WIDTH-1:0] r_addr_a, r_addr_b;
  logic [TW_WIDTH-1:0]   r_twiddle;
  logic [3:0]            r_stage;

  // Scan limits and bit-reversed scan index for the latched transform size
  always_comb begin
    w_legal  = (i_log2n != 4'd0) && (32'(i_log2n) <= ADDR_WIDTH);
    w_n_m1   = ADDR_WIDTH'((32'd1 << r_log2n) - 32'd1);
    w_k_last = ADDR_WIDTH'(((32'd1 << r_log2n) >> 1) - 32'd1);
    w_rev_full = '0;
    for (int unsigned j = 0; j < ADDR_WIDTH; j++) begin
      w_rev_full[j] = r_idx[ADDR_WIDTH-1-j];
    end
    w_rev      = w_rev_full >> (ADDR_WIDTH - 32'(r_log2n));
    w_swap_hit = (w_rev > r_idx);
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_log2n <= '0;
      r_idx   <= '0;
      r_k     <= '0;
      r_s     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_log2n <= w_log2n_nxt;
      r_idx   <= w_idx_nxt;
      r_k     <= w_k_nxt;
      r_s     <= w_s_nxt;
    end
  end

  // Next state and next counter values
  always_comb begin
    w_state_nxt = r_state;
    w_log2n_nxt = r_log2n;
    w_idx_nxt   = r_idx;
    w_k_nxt     = r_k;
    w_s_nxt     = r_s;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_legal) begin
          w_state_nxt = S_BITREV;
          w_log2n_nxt = i_log2n;
          w_idx_nxt   = '0;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end
      end
      S_BITREV: begin
        if (w_swap_hit) begin
          w_state_nxt = S_ISSUE;
        end else if (r_idx == w_n_m1) begin
          w_state_nxt = S_ISSUE;
          w_k_nxt     = '0;
          w_s_nxt     = '0;
        end else begin
          w_idx_nxt = r_idx + ADDR_WIDTH'(1);
        end
      end
      S_ISSUE: begin
        if (op.i_op_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (op.i_op_done) begin
          if (r_op_swap) begin
            w_state_nxt = S_BITREV;
            w_idx_nxt   = r_idx + ADDR_WIDTH'(1);
          end else if (r_k == w_k_last) begin
            if (r_s == r_log2n - 4'd1) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_ISSUE;
              w_k_nxt     = '0;
              w_s_nxt     = r_s + 4'd1;
            end
          end else begin
            w_state_nxt = S_ISSUE;
            w_k_nxt     = r_k + ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Butterfly operand pair and twiddle for the next (stage, k)
  always_comb begin
    w_half  = ADDR_WIDTH'(1) << w_s_nxt;
    w_pos   = w_k_nxt & (w_half - ADDR_WIDTH'(1));
    w_grp   = w_k_nxt >> w_s_nxt;
    w_bf_a  = (w_grp << (5'(w_s_nxt) + 5'd1)) | w_pos;
    w_bf_b  = w_bf_a + w_half;
    w_bf_tw = TW_WIDTH'(w_pos << (r_log2n - 4'd1 - w_s_nxt));
  end

  // Next values of the registered outputs
  always_comb begin
    w_busy_nxt     = (w_state_nxt == S_BITREV) || (w_state_nxt == S_ISSUE) ||
                     (w_state_nxt == S_WAIT_DONE);
    w_calc_end_nxt = (w_state_nxt == S_DONE);
    w_valid_nxt    = (w_state_nxt == S_ISSUE);
    w_load         = (w_state_nxt == S_ISSUE) && (r_state != S_ISSUE);
    w_clear        = (r_state == S_IDLE) && (w_state_nxt == S_BITREV);
    w_swap_nxt     = (r_state == S_BITREV) && w_swap_hit;
  end

  // Output and payload registers; payload only changes when a new request is loaded
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_busy     <= 1'b0;
      r_calc_end <= 1'b0;
      r_op_valid <= 1'b0;
      r_op_swap  <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_twiddle  <= '0;
      r_stage    <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_calc_end <= w_calc_end_nxt;
      r_op_valid <= w_valid_nxt;
      if (w_clear) begin
        r_op_swap <= 1'b0;
        r_addr_a  <= '0;
        r_addr_b  <= '0;
        r_twiddle <= '0;
        r_stage   <= '0;
      end else if (w_load) begin
        r_op_swap <= w_swap_nxt;
        if (w_swap_nxt) begin
          r_addr_a  <= r_idx;
          r_addr_b  <= w_rev;
          r_twiddle <= '0;
          r_stage   <= '0;
        end else begin
          r_addr_a  <= w_bf_a;
          r_addr_b  <= w_bf_b;
          r_twiddle <= w_bf_tw;
          r_stage   <= w_s_nxt;
        end
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_calc_end     = r_calc_end;
  assign op.o_op_valid  = r_op_valid;
  assign op.o_op_swap   = r_op_swap;
  assign op.o_addr_a    = r_addr_a;
  assign op.o_addr_b    = r_addr_b;
  assign op.o_twiddle   = r_twiddle;
  assign op.o_stage     = r_stage;
endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: emulates the execution unit with random
// ready/done latencies and checks every operation against an FFT schedule model.
module tb_fft_sequencer;
  localparam int unsigned AW = 12;
  localparam int unsigned TW = AW - 1;

  typedef struct packed {
    logic          swap;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [TW-1:0] tw;
    logic [3:0]    stage;
  } op_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_log2n;
  logic       o_busy;
  logic       o_calc_end;

  fft_sequencer_if #(.ADDR_WIDTH(AW)) op_if ();

  fft_sequencer #(.ADDR_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rstn     (rst_n),
    .i_start    (i_start),
    .i_log2n    (i_log2n),
    .o_busy     (o_busy),
    .o_calc_end (o_calc_end),
    .op         (op_if)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  int  obs_swaps;
  int  obs_bflies;
  int  n_calc_end = 0;
  op_t exp_q[$];

  // Count calc_end pulses away from the active edge
  always @(negedge clk) if (o_calc_end === 1'b1) n_calc_end++;

  function automatic op_t cur_op();
    return {op_if.o_op_swap, op_if.o_addr_a, op_if.o_addr_b, op_if.o_twiddle, op_if.o_stage};
  endfunction

  // Reference schedule: swap list from an arithmetic bit reversal, then
  // butterflies enumerated by stage, group base and position within the group.
  function automatic void build_ops(input int L);
    int  n, r, half;
    op_t e;
    exp_q.delete();
    n = 1 << L;
    for (int i = 0; i < n; i++) begin
      r = 0;
      for (int bit_i = 0; bit_i < L; bit_i++)
        if (((i >> bit_i) & 1) == 1) r = r | (1 << (L - 1 - bit_i));
      if (r > i) begin
        e.swap = 1'b1; e.a = AW'(i); e.b = AW'(r); e.tw = '0; e.stage = '0;
        exp_q.push_back(e);
      end
    end
    for (int s = 0; s < L; s++) begin
      half = 1 << s;
      for (int base = 0; base < n; base += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          e.swap  = 1'b0;
          e.a     = AW'(base + j);
          e.b     = AW'(base + j + half);
          e.tw    = TW'(j * (n / (2 * half)));
          e.stage = 4'(s);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic drive_noise(input bit noise, input bit allow_done);
    i_start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    i_log2n        = 4'($urandom_range(0, 15));
    op_if.i_op_done = (noise && allow_done) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Start a transform of size 2^L and serve its operations; stop_idx >= 0
  // returns as soon as that operation's request becomes visible.
  task automatic run_transform(input int L, input int rdy_max, input int done_max,
                               input int bp_idx, input bit noise, input int stop_idx);
    op_t got;
    int  wait_cnt, dly, total;
    build_ops(L);
    total      = exp_q.size();
    obs_swaps  = 0;
    obs_bflies = 0;
    i_log2n    = 4'(L);
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start L=%0d: got %b want 1", L, o_busy);
    end
    for (int idx = 0; idx < total; idx++) begin
      wait_cnt = 0;
      while (op_if.o_op_valid !== 1'b1 && wait_cnt < 2 * (1 << L) + 8) begin
        drive_noise(noise, 1'b1);
        @(negedge clk);
        wait_cnt++;
      end
      drive_noise(1'b0, 1'b0);
      n_cmp++;
      if (op_if.o_op_valid !== 1'b1) begin
        n_err++; $display("FAIL valid_timeout L=%0d op=%0d: valid %b want 1", L, idx, op_if.o_op_valid);
        return;
      end
      if (idx == stop_idx) return;
      got = cur_op();
      n_cmp++;
      if (got !== exp_q[idx]) begin
        n_err++; $display("FAIL op_payload L=%0d op=%0d: got %h want %h", L, idx, got, exp_q[idx]);
      end
      n_cmp++;
      if (o_busy !== 1'b1) begin
        n_err++; $display("FAIL busy_during L=%0d op=%0d: got %b want 1", L, idx, o_busy);
      end
      dly = (idx == bp_idx) ? 5 : $urandom_range(0, rdy_max);
      op_if.i_op_ready = 1'b0;
      repeat (dly) begin
        drive_noise(noise, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (op_if.o_op_valid !== 1'b1 || cur_op() !== got) begin
          n_err++; $display("FAIL payload_stable L=%0d op=%0d: valid %b got %h want %h",
                            L, idx, op_if.o_op_valid, cur_op(), got);
        end
      end
      drive_noise(1'b0, 1'b0);
      op_if.i_op_ready = 1'b1;
      @(negedge clk);
      op_if.i_op_ready = 1'b0;
      if (got.swap) obs_swaps++; else obs_bflies++;
      n_cmp++;
      if (op_if.o_op_valid !== 1'b0) begin
        n_err++; $display("FAIL valid_after_xfer L=%0d op=%0d: got %b want 0", L, idx, op_if.o_op_valid);
      end
      dly = $urandom_range(0, done_max);
      repeat (dly) begin
        drive_noise(noise, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (op_if.o_op_valid !== 1'b0) begin
          n_err++; $display("FAIL valid_in_wait L=%0d op=%0d: got %b want 0", L, idx, op_if.o_op_valid);
        end
      end
      drive_noise(1'b0, 1'b0);
      op_if.i_op_done = 1'b1;
      @(negedge clk);
      op_if.i_op_done = 1'b0;
      if (idx == total - 1) begin
        n_cmp++;
        if (o_calc_end !== 1'b1 || o_busy !== 1'b0) begin
          n_err++; $display("FAIL calc_end_pulse L=%0d: calc_end %b busy %b want 1 0", L, o_calc_end, o_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (o_calc_end !== 1'b0 || o_busy !== 1'b0) begin
          n_err++; $display("FAIL calc_end_drop L=%0d: calc_end %b busy %b want 0 0", L, o_calc_end, o_busy);
        end
      end else if (!got.swap) begin
        n_cmp++;
        if (op_if.o_op_valid !== 1'b1) begin
          n_err++; $display("FAIL next_req_latency L=%0d op=%0d: valid %b want 1", L, idx, op_if.o_op_valid);
        end
      end
    end
  endtask

  task automatic check_counts(input string name, input int sw, input int bf);
    n_cmp++;
    if (obs_swaps !== sw || obs_bflies !== bf) begin
      n_err++; $display("FAIL %s_counts: got swaps %0d bflies %0d want %0d %0d", name, obs_swaps, obs_bflies, sw, bf);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({o_busy, o_calc_end, cur_op(), op_if.o_op_valid} !== '0) begin
      n_err++; $display("FAIL %s: busy %b calc_end %b valid %b payload %h want all 0",
                        name, o_busy, o_calc_end, op_if.o_op_valid, cur_op());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_log2n = '0;
    op_if.i_op_ready = 1'b0; op_if.i_op_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_l1();
    run_transform(1, 0, 0, -1, 1'b0, -1);
    check_counts("l1", 0, 1);
  endtask

  task automatic test_l3();
    run_transform(3, 2, 3, -1, 1'b0, -1);
    check_counts("l3", 2, 12);
  endtask

  task automatic test_backpressure();
    run_transform(2, 0, 1, 1, 1'b0, -1);
    check_counts("backpressure", 1, 4);
  endtask

  task automatic test_ignored_starts();
    int bad[2] = '{0, 13};
    foreach (bad[i]) begin
      i_log2n = 4'(bad[i]); i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (2) begin
        n_cmp++;
        if (o_busy !== 1'b0 || op_if.o_op_valid !== 1'b0) begin
          n_err++; $display("FAIL illegal_start log2n=%0d: busy %b valid %b want 0 0", bad[i], o_busy, op_if.o_op_valid);
        end
        @(negedge clk);
      end
    end
    run_transform(2, 3, 3, -1, 1'b1, -1);
    check_counts("start_while_busy", 1, 4);
  endtask

  task automatic test_reset_mid();
    run_transform(3, 1, 1, -1, 1'b0, 6);
    n_cmp++;
    if (op_if.o_op_valid !== 1'b1 || op_if.o_stage !== 4'd1) begin
      n_err++; $display("FAIL reached_stage1: valid %b stage %0d want 1 1", op_if.o_op_valid, op_if.o_stage);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_all_zero("no_reissue_after_reset");
    end
    run_transform(3, 2, 2, -1, 1'b0, -1);
    check_counts("restart_l3", 2, 12);
  endtask

  task automatic test_random();
    int L;
    repeat (4) begin
      L = $urandom_range(1, 6);
      run_transform(L, 3, 3, -1, 1'b1, -1);
      check_counts("random", obs_swaps_model(L), (1 << (L - 1)) * L);
    end
  endtask

  function automatic int obs_swaps_model(input int L);
    int c = 0;
    build_ops(L);
    foreach (exp_q[i]) if (exp_q[i].swap) c++;
    return c;
  endfunction

  task automatic test_l12();
    int pulses_before;
    pulses_before = n_calc_end;
    run_transform(12, 0, 0, -1, 1'b0, -1);
    check_counts("l12", 2016, 24576);
    n_cmp++;
    if (n_calc_end - pulses_before !== 1) begin
      n_err++; $display("FAIL l12_calc_end_pulses: got %0d want 1", n_calc_end - pulses_before);
    end
  endtask

  initial begin
    test_reset();
    test_l1();
    test_l3();
    test_backpressure();
    test_ignored_starts();
    test_reset_mid();
    test_random();
    test_l12();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Sequences the in-place radix-2 decimation-in-time FFT over the shared sample RAM once the AXI bridge has finished loading samples. It first runs a bit-reversal permutation pass by issuing swap operations, then issues every butterfly of every stage with its RAM address pair and twiddle index. A separate butterfly/swap execution unit performs the RAM traffic and reports completion. When the last butterfly completes, the sequencer pulses the calc-end flag that releases the bridge's read phase.

## Interface
- `ADDR_WIDTH`, default 12: sample index width; maximum N is 2^ADDR_WIDTH.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  start request, normally driven by the bridge's data-loaded pulse.
- `i_log2n`  in  4  log2 of the sample count; legal range 1..ADDR_WIDTH; sampled only on an accepted start.
- `o_busy`  out  1  high from the cycle after an accepted start until calc_end.
- `o_calc_end`  out  1  one-cycle pulse when the transform is complete.
- `o_op_valid`  out  1  operation request to the execution unit.
- `i_op_ready`  in  1  execution unit accepts the request.
- `i_op_done`  in  1  execution unit has finished the accepted operation, including writeback.
- `o_op_swap`  out  1  1 = swap RAM[a]/RAM[b]; 0 = butterfly.
- `o_addr_a`  out  ADDR_WIDTH  upper/first operand index.
- `o_addr_b`  out  ADDR_WIDTH  lower/second operand index.
- `o_twiddle`  out  ADDR_WIDTH-1  twiddle index k into W_N^k; 0 for swaps.
- `o_stage`  out  4  current stage, 0..log2n-1; 0 during bit-reversal.

## Operation
- States: IDLE, BITREV, ISSUE, WAIT_DONE, DONE.
- IDLE: when `i_start`=1 and `i_log2n` is legal, latch L=`i_log2n` and N=2^L, clear the index counter, and go to BITREV. An illegal `i_log2n` (0 or >ADDR_WIDTH) ignores the start.
- BITREV: scans i=0..N-1 at one index per cycle. r=bit-reverse of i over L bits.
  - If r>i: issue a swap with a=i, b=r (ISSUE, `o_op_swap`=1).
  - Otherwise: advance i.
  - After i=N-1: go to butterfly stage s=0, k=0.
- Butterfly k of stage s, with k in 0..N/2-1 and half=2^s:
  - pos=k&(half-1), grp=k>>s.
  - a=(grp<<(s+1))|pos, b=a+half.
  - twiddle=pos<<(L-1-s).
- ISSUE: `o_op_valid`=1 with stable payload until `i_op_ready`=1, then go to WAIT_DONE.
- WAIT_DONE: `o_op_valid`=0. On `i_op_done`, advance:
  - During bit-reversal: resume BITREV at i+1.
  - Otherwise k+1. At k=N/2-1, wrap k to 0 and increment s. At s=L-1 with k=N/2-1, go to DONE.
- DONE: pulse `o_calc_end` and drop `o_busy`, then return to IDLE.
- Ignored events:
  - `i_start` in any state other than IDLE.
  - `i_op_done` outside WAIT_DONE.
- Operations complete strictly one at a time; there is no overlap of operations.
- All index arithmetic is modulo 2^ADDR_WIDTH. Counters must not overflow for N=2^ADDR_WIDTH.

## Timing
- Reset values: `o_busy`=0, `o_calc_end`=0, `o_op_valid`=0, `o_op_swap`=0, `o_addr_a`=0, `o_addr_b`=0, `o_twiddle`=0, `o_stage`=0; state=IDLE.
- Start accepted at cycle t: `o_busy`=1 from t+1, and the BITREV scan begins at t+1.
- Payload outputs are registered and stable for every cycle in which `o_op_valid`=1.
- Handshake: transfer occurs on the cycle where `o_op_valid` and `i_op_ready` are both 1. `o_op_valid` is 0 from the following cycle.
- `i_op_done` may arrive in the cycle after the handshake or later.
- Next request: `i_op_done` at cycle d gives the next `o_op_valid` at d+1, except when a BITREV scan with no swaps intervenes.
- End of transform: the last `i_op_done` at cycle d gives `o_calc_end`=1 and `o_busy`=0 at d+1, and IDLE at d+2.
- Reset asserted mid-transform: all outputs return to reset values immediately and no operation is reissued.

## Test plan
- L=1: start -> no swaps; one butterfly a=0, b=1, tw=0; calc_end one cycle after its done.
- L=3: start -> swaps (1,4), (3,6).
  - Stage 0: (0,1), (2,3), (4,5), (6,7), tw 0.
  - Stage 1: (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - Stage 2: (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - Then calc_end.
- Backpressure: hold `i_op_ready`=0 for 5 cycles on the first butterfly -> valid and payload stay stable; exactly one transfer occurs.
- Start with `i_log2n`=0 or 13, and a second start while busy -> ignored; `o_busy` is unchanged.
- Assert reset during stage 1 of L=3 -> all outputs return to 0. A fresh start then runs the full L=3 sequence from the first swap.
- L=12: count operations -> 2016 swaps and 24576 butterflies; exactly one calc_end pulse.
